// File: rtl/simple_proc_pkg.sv
// simple_proc_pkg: shared definitions for the multi-cycle processor.
//   - opcode encoding, FSM state encoding, instruction field positions
//   - helper to classify memory instructions
package simple_proc_pkg;

   localparam int unsigned InstrW  = 18;
   localparam int unsigned RegIdxW = 5;

   // Instruction field positions: opcode | Ya | Yb | Yc
   localparam int unsigned OpMsb = 17;
   localparam int unsigned OpLsb = 15;
   localparam int unsigned YaMsb = 14;
   localparam int unsigned YaLsb = 10;
   localparam int unsigned YbMsb = 9;
   localparam int unsigned YbLsb = 5;
   localparam int unsigned YcMsb = 4;
   localparam int unsigned YcLsb = 0;

   typedef enum logic [2:0] {
      OpAdd    = 3'b000,
      OpSub    = 3'b001,
      OpMove   = 3'b010,
      OpShift  = 3'b011,
      OpLoad   = 3'b100,
      OpStore  = 3'b101,
      OpJump   = 3'b110,
      OpBranch = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem
   } state_e;

   function automatic logic is_mem_op(input op_e op);
      return (op == OpLoad) || (op == OpStore);
   endfunction

endpackage

// File: rtl/simple_proc_alu.sv
// simple_proc_alu: combinational datapath for ADD/SUB/MOVE/SHIFT (and MUL).
// Optional feature macro: SIMPLE_PROC_MUL_EN -- when defined, the JUMP opcode
// produces b*c (the caller decides whether that encoding is a multiply).
// Ports:
//   op_i     - decoded opcode
//   a_i      - Regs[Ya] (shift source)
//   b_i/c_i  - Regs[Yb], Regs[Yc]
//   result_o - DATA_W-bit result, modulo 2^DATA_W
module simple_proc_alu
   import simple_proc_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  op_e               op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] c_i,
   output logic [DATA_W-1:0] result_o
);

   localparam int unsigned ShW = $clog2(DATA_W);

   always_comb begin
      result_o = '0;
      case (op_i)
         OpAdd:   result_o = b_i + c_i;
         OpSub:   result_o = b_i - c_i;
         OpMove:  result_o = {b_i[DATA_W-1:8], c_i[7:0]};
         OpShift: result_o = a_i << b_i[ShW-1:0];
`ifdef SIMPLE_PROC_MUL_EN
         OpJump:  result_o = b_i * c_i;
`endif
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/simple_proc_mc.sv
// simple_proc_mc: multi-cycle processor, IDLE/FETCH/DECODE/EXEC/MEM.
// Optional feature macro: SIMPLE_PROC_MUL_EN -- JUMP with instr[1:0]!=00
// becomes a multiply into Regs[Ya]; otherwise that encoding is a no-op.
// Ports:
//   clk, rst (sync, active-high)
//   valid_in         - start / keep running
//   imem_we/addr/wdata - instruction load, honoured only while idle
//   dbg_raddr/rdata  - combinational register readback
//   busy             - not idle
//   valid_out        - one-cycle pulse on reaching END_ADDR
module simple_proc_mc
   import simple_proc_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned NREGS      = 32,
   parameter int unsigned IMEM_DEPTH = 128,
   parameter int unsigned DMEM_DEPTH = 512,
   parameter int unsigned END_ADDR   = IMEM_DEPTH - 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid_in,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   input  logic [17:0]                   imem_wdata,
   input  logic [4:0]                    dbg_raddr,
   output logic [DATA_W-1:0]             dbg_rdata,
   output logic                          busy,
   output logic                          valid_out
);

   localparam int unsigned PcW = $clog2(IMEM_DEPTH);
   localparam int unsigned DaW = $clog2(DMEM_DEPTH);

   state_e              state_q, state_d;
   logic [PcW-1:0]      pc_q, pc_d, pc_inc;
   logic [InstrW-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;

   logic [DATA_W-1:0]   regs_q [NREGS];
   logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];
   logic [InstrW-1:0]   imem_q [IMEM_DEPTH];

   op_e                 op;
   logic [RegIdxW-1:0]  ya, yb, yc;
   logic                jump_rel;
   logic [DATA_W-1:0]   alu_res;
   logic                rf_we;
   logic [DATA_W-1:0]   rf_wdata;
   logic                dmem_we;
   logic [DaW-1:0]      dmem_addr;

   function automatic logic [DATA_W-1:0] rf_read(input logic [RegIdxW-1:0] idx);
      if (32'(idx) < NREGS) return regs_q[idx];
      return '0;
   endfunction

   assign op        = op_e'(ir_q[OpMsb:OpLsb]);
   assign ya        = ir_q[YaMsb:YaLsb];
   assign yb        = ir_q[YbMsb:YbLsb];
   assign yc        = ir_q[YcMsb:YcLsb];
   assign jump_rel  = (ir_q[1:0] == 2'b00);
   assign dmem_addr = b_q[DaW-1:0];
   assign pc_inc    = (pc_q == PcW'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

   simple_proc_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op_i     (op),
      .a_i      (a_q),
      .b_i      (b_q),
      .c_i      (c_q),
      .result_o (alu_res)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (valid_in) state_d = StFetch;
         // Reaching END_ADDR stops before the instruction there is fetched.
         StFetch:  state_d = (pc_q == PcW'(END_ADDR)) ? StIdle : StDecode;
         StDecode: state_d = StExec;
         StExec: begin
            if (is_mem_op(op)) state_d = StMem;
            else               state_d = valid_in ? StFetch : StIdle;
         end
         StMem:    state_d = valid_in ? StFetch : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy      = (state_q != StIdle);
      valid_out = (state_q == StFetch) && (pc_q == PcW'(END_ADDR));
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      rf_we    = 1'b0;
      rf_wdata = alu_res;
      dmem_we  = 1'b0;
      unique case (state_q)
         StIdle:  if (valid_in) pc_d = '0;
         StFetch: ir_d = imem_q[pc_q];
         StDecode: begin
            a_d = rf_read(ya);
            b_d = rf_read(yb);
            c_d = rf_read(yc);
         end
         StExec: begin
            pc_d = pc_inc;
            case (op)
               OpAdd, OpSub, OpMove, OpShift: rf_we = 1'b1;
               OpJump: begin
                  if (jump_rel) begin
                     pc_d = pc_q + a_q[PcW-1:0];
                  end else begin
`ifdef SIMPLE_PROC_MUL_EN
                     rf_we = 1'b1;
`endif
                  end
               end
               OpBranch: if (b_q == c_q) pc_d = a_q[PcW-1:0];
               default: ;
            endcase
         end
         StMem: begin
            if (op == OpLoad) begin
               rf_we    = 1'b1;
               rf_wdata = dmem_q[dmem_addr];
            end else begin
               dmem_we  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
         ir_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         c_q  <= '0;
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
         a_q  <= a_d;
         b_q  <= b_d;
         c_q  <= c_d;
      end
   end

   // Register file: reset pattern Regs[i]=i for i<16; writes beyond NREGS dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= (i < 16) ? DATA_W'(i) : '0;
         end
      end else if (rf_we && (32'(ya) < NREGS)) begin
         regs_q[ya] <= rf_wdata;
      end
   end

   // Memories keep their contents across reset; rst only blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && dmem_we) dmem_q[dmem_addr] <= a_q;
      if (!rst && imem_we && (state_q == StIdle)) imem_q[imem_addr] <= imem_wdata;
   end

   always_comb begin
      dbg_rdata = rf_read(dbg_raddr);
   end

endmodule

// File: tb/tb_simple_proc_mc.sv
// Bench for simple_proc_mc: instruction-level reference model, per-cycle
// compare of busy/valid_out/dbg_rdata, directed literal checks, random programs.
module tb_simple_proc_mc;

   localparam int NR = 24;
   localparam int ID = 16;
   localparam int DD = 16;
   localparam int EA = 1;

   localparam int OP_ADD = 0, OP_SUB = 1, OP_MOVE = 2, OP_SHIFT = 3;
   localparam int OP_LOAD = 4, OP_STORE = 5, OP_JUMP = 6, OP_BRANCH = 7;

   logic        clk = 1'b0;
   logic        rst, valid_in, imem_we;
   logic [3:0]  imem_addr;
   logic [17:0] imem_wdata;
   logic [4:0]  dbg_raddr;
   logic [15:0] dbg_rdata;
   logic        busy, valid_out;

   always #5 clk = ~clk;

   simple_proc_mc #(
      .DATA_W     (16),
      .NREGS      (NR),
      .IMEM_DEPTH (ID),
      .DMEM_DEPTH (DD),
      .END_ADDR   (EA)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata),
      .busy       (busy),
      .valid_out  (valid_out)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 0, sync = 0, exp_busy = 0, exp_vout = 0;

   // Reference model state
   logic [15:0] m_regs [32];
   logic [15:0] m_dmem [DD];
   logic [17:0] m_imem [ID];
   int          m_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   function automatic logic [15:0] m_rd(input int idx);
      return (idx < NR) ? m_regs[idx] : 16'h0;
   endfunction

   task automatic m_wr(input int idx, input longint v);
      if (idx < NR) m_regs[idx] = 16'(v % 65536);
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = (i < 16) ? 16'(i) : 16'h0;
      m_pc = 0;
   endtask

   // Execute one instruction at m_pc; returns its cycle count.
   task automatic model_step(output int len);
      int unsigned wi;
      int          op, ya, yb, yc, npc;
      longint      ra, rb, rc;
      wi  = 32'(m_imem[m_pc]);
      op  = int'(wi / 32768);
      ya  = int'((wi / 1024) % 32);
      yb  = int'((wi / 32) % 32);
      yc  = int'(wi % 32);
      ra  = longint'(m_rd(ya));
      rb  = longint'(m_rd(yb));
      rc  = longint'(m_rd(yc));
      len = 3;
      npc = (m_pc + 1) % ID;
      case (op)
         OP_ADD:   m_wr(ya, rb + rc);
         OP_SUB:   m_wr(ya, rb + 65536 - rc);
         OP_MOVE:  m_wr(ya, (rb / 256) * 256 + rc % 256);
         OP_SHIFT: m_wr(ya, ra * (longint'(1) << (rb % 16)));
         OP_LOAD: begin
            m_wr(ya, longint'(m_dmem[int'(rb % DD)]));
            len = 4;
         end
         OP_STORE: begin
            m_dmem[int'(rb % DD)] = 16'(ra);
            len = 4;
         end
         OP_JUMP: begin
            if (yc % 4 == 0) npc = int'((m_pc + ra) % ID);
`ifdef SIMPLE_PROC_MUL_EN
            else m_wr(ya, rb * rc);
`endif
         end
         default: if (rb == rc) npc = int'(ra % ID);
      endcase
      m_pc = npc;
   endtask

   function automatic logic [17:0] enc(input int op, input int ya, input int yb, input int yc);
      return 18'(op * 32768 + ya * 1024 + yb * 32 + yc);
   endfunction

   // Per-cycle comparison of DUT outputs against the model's expectations.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", 32'(busy), 32'(exp_busy));
         check("valid_out", 32'(valid_out), 32'(exp_vout));
         if (sync && !exp_busy) check("dbg_rdata", 32'(dbg_rdata), 32'(m_rd(int'(dbg_raddr))));
      end
   end

   task automatic do_reset();
      cmp_en = 0;
      @(posedge clk); #1;
      rst = 1; valid_in = 0; imem_we = 0;
      @(posedge clk); #1;
      rst = 0;
      m_reset();
      exp_busy = 0; exp_vout = 0; sync = 1; cmp_en = 1;
   endtask

   task automatic imem_write(input int a, input logic [17:0] w);
      @(posedge clk); #1;
      imem_we = 1; imem_addr = 4'(a); imem_wdata = w;
      @(posedge clk); #1;
      imem_we = 0;
      m_imem[a] = w;
   endtask

   task automatic peek(input string name, input int idx, input int exp);
      @(posedge clk); #1;
      dbg_raddr = 5'(idx);
      #1;
      check(name, 32'(dbg_rdata), 32'(exp));
   endtask

   // Run from PC 0 for at most cap instructions. busy_wr tries an imem write
   // of SUB R16,R3,R4 to address 0 while busy.
   task automatic run(input int cap, input bit busy_wr, output int busy_cnt, output int pulses);
      int lens[$];
      bit nat;
      int total, d, sd, l;
      sync = 0;
      nat  = 0;
      m_pc = 0;
      for (int k = 0; k < cap; k++) begin
         if (m_pc == EA) begin
            nat = 1;
            break;
         end
         model_step(l);
         lens.push_back(l);
      end
      total = int'(nat);
      foreach (lens[i]) total += lens[i];
      d  = nat ? lens.size() : lens.size() - 1;
      sd = 0;
      for (int i = 0; i < d; i++) sd += lens[i];
      busy_cnt = 0;
      pulses   = 0;
      exp_busy = 0; exp_vout = 0;
      @(posedge clk); #1;
      valid_in = 1;
      @(posedge clk); #1;
      for (int c = 0; c < total + 2; c++) begin
         exp_busy = (c < total);
         exp_vout = nat && (c == total - 1);
         if (c == sd) valid_in = 0;
         if (busy_wr && c == 1) begin
            imem_we = 1; imem_addr = 4'd0; imem_wdata = enc(OP_SUB, 16, 3, 4);
         end
         if (busy_wr && c == 2) imem_we = 0;
         if (valid_out) pulses++;
         if (busy) busy_cnt++;
         @(posedge clk); #1;
      end
      sync = 1;
   endtask

   int bc, pc;

   initial begin
      rst = 1; valid_in = 0; imem_we = 0; imem_addr = '0; imem_wdata = '0; dbg_raddr = '0;
      do_reset();

      // Give every memory word a known value.
      for (int a = 1; a < ID; a++) imem_write(a, 18'($urandom));
      for (int a = 0; a < DD; a++) begin
         imem_write(0, enc(OP_STORE, a, a, 0));
         run(8, 0, bc, pc);
      end

      do_reset();
      check("reset_busy", 32'(busy), 0);
      check("reset_valid_out", 32'(valid_out), 0);
      peek("reset_r3", 3, 3);
      peek("reset_r20", 20, 0);
      peek("read_oob_r30", 30, 0);

      imem_write(0, enc(OP_ADD, 16, 3, 4));
      run(8, 0, bc, pc);
      check("add_pulses", 32'(pc), 1);
      check("add_busy_cycles", 32'(bc), 4);
      peek("add_r16", 16, 7);

      imem_write(0, enc(OP_STORE, 5, 2, 0));
      run(8, 0, bc, pc);
      check("store_busy_cycles", 32'(bc), 5);
      imem_write(0, enc(OP_LOAD, 17, 2, 0));
      run(8, 0, bc, pc);
      check("load_busy_cycles", 32'(bc), 5);
      peek("load_r17", 17, 5);

      imem_write(0, enc(OP_ADD, 20, 1, 0));
      run(8, 0, bc, pc);
      peek("add_r20", 20, 1);
      imem_write(0, enc(OP_BRANCH, 20, 3, 3));
      run(8, 0, bc, pc);
      check("branch_taken_pulses", 32'(pc), 1);
      check("branch_taken_cycles", 32'(bc), 4);
      imem_write(0, enc(OP_BRANCH, 20, 3, 4));
      run(8, 0, bc, pc);
      check("branch_not_taken_cycles", 32'(bc), 4);

      imem_write(0, enc(OP_SHIFT, 1, 3, 0));
      run(8, 0, bc, pc);
      peek("shift_r1", 1, 8);
      imem_write(0, enc(OP_MOVE, 18, 15, 5));
      run(8, 0, bc, pc);
      peek("move_r18", 18, 5);

      // Yc=R3 keeps instr[1:0]!=00, so this is the multiply encoding.
      imem_write(0, enc(OP_JUMP, 21, 4, 3));
      run(8, 0, bc, pc);
`ifdef SIMPLE_PROC_MUL_EN
      peek("mul_r21", 21, 12);
`else
      peek("mul_r21", 21, 0);
`endif

      imem_write(0, enc(OP_ADD, 25, 3, 4));
      run(8, 0, bc, pc);
      peek("write_oob_r25", 25, 0);

      // Reset while ADD R6,R7,R8 is in EXEC.
      imem_write(0, enc(OP_ADD, 6, 7, 8));
      cmp_en = 0; sync = 0;
      @(posedge clk); #1; valid_in = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("exec_busy", 32'(busy), 1);
      rst = 1; valid_in = 0;
      @(posedge clk); #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_valid_out", 32'(valid_out), 0);
      rst = 0;
      m_reset();
      exp_busy = 0; exp_vout = 0; sync = 1; cmp_en = 1;
      peek("midrst_r6", 6, 6);
      run(8, 0, bc, pc);
      peek("imem_kept_r6", 6, 15);

      imem_write(0, enc(OP_ADD, 16, 3, 4));
      run(8, 1, bc, pc);
      run(8, 0, bc, pc);
      peek("busy_write_ignored_r16", 16, 7);
      imem_write(0, enc(OP_LOAD, 17, 2, 0));
      run(8, 0, bc, pc);
      peek("dmem_kept_r17", 17, 5);

      // Random programs against the model.
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 19) == 0) do_reset();
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
            imem_write(int'($urandom_range(0, ID - 1)), 18'($urandom));
         end
         run(int'($urandom_range(1, 8)), 0, bc, pc);
         for (int j = 0; j < ((it % 10 == 0) ? 32 : 4); j++) begin
            @(posedge clk); #1;
            dbg_raddr = (it % 10 == 0) ? 5'(j) : 5'($urandom);
         end
      end

      @(posedge clk); #1;
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
